// File: rtl/uart_tx_parity.sv
// UART transmitter: start bit, DBIT data bits LSB-first, one parity bit, stop bit.
// Bit timing is driven by a 16x oversampling s_tick enable.
module uart_tx_parity #(
    parameter int DBIT       = 8,
    parameter int SB_TICK    = 16,
    parameter int PARITY_ODD = 0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tx_start,
    input  logic       s_tick,
    input  logic [7:0] din,
    output logic       tx,
    output logic       tx_done_tick,
    output logic       busy
);

    // Tick counter must also reach SB_TICK-1 for 1.5/2 stop-bit settings.
    localparam int SW = (SB_TICK > 16) ? $clog2(SB_TICK) : 4;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    state_t        state_q, state_d;
    logic [SW-1:0] s_q, s_d;
    logic [2:0]    n_q, n_d;
    logic [7:0]    b_q, b_d;
    logic          p_q, p_d;
    logic          tx_q, tx_d;

    // State and datapath registers; reset returns the line to idle-high.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            s_q     <= '0;
            n_q     <= 3'd0;
            b_q     <= 8'd0;
            p_q     <= 1'b0;
            tx_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            s_q     <= s_d;
            n_q     <= n_d;
            b_q     <= b_d;
            p_q     <= p_d;
            tx_q    <= tx_d;
        end
    end

    // Next-state logic; everything advances only on s_tick.
    always_comb begin
        state_d      = state_q;
        s_d          = s_q;
        n_d          = n_q;
        b_d          = b_q;
        p_d          = p_q;
        tx_done_tick = 1'b0;
        case (state_q)
            IDLE: begin
                if (tx_start) begin
                    state_d = START;
                    b_d     = din;
                    p_d     = (PARITY_ODD != 0) ? 1'b1 : 1'b0;
                    s_d     = '0;
                end else begin
                    state_d = IDLE;
                end
            end
            START: begin
                if (s_tick) begin
                    if (s_q == SW'(15)) begin
                        s_d     = '0;
                        n_d     = 3'd0;
                        state_d = DATA;
                    end else begin
                        s_d = s_q + SW'(1);
                    end
                end else begin
                    s_d = s_q;
                end
            end
            DATA: begin
                if (s_tick) begin
                    if (s_q == SW'(15)) begin
                        s_d = '0;
                        p_d = p_q ^ b_q[0];
                        b_d = b_q >> 1;
                        if (n_q == 3'(DBIT - 1)) begin
                            state_d = PARITY;
                        end else begin
                            n_d = n_q + 3'd1;
                        end
                    end else begin
                        s_d = s_q + SW'(1);
                    end
                end else begin
                    s_d = s_q;
                end
            end
            PARITY: begin
                if (s_tick) begin
                    if (s_q == SW'(15)) begin
                        s_d     = '0;
                        state_d = STOP;
                    end else begin
                        s_d = s_q + SW'(1);
                    end
                end else begin
                    s_d = s_q;
                end
            end
            STOP: begin
                if (s_tick) begin
                    if (s_q == SW'(SB_TICK - 1)) begin
                        s_d          = '0;
                        tx_done_tick = 1'b1;
                        state_d      = IDLE;
                    end else begin
                        s_d = s_q + SW'(1);
                    end
                end else begin
                    s_d = s_q;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Line level follows the next state so tx is a clean register output.
    always_comb begin
        tx_d = 1'b1;
        case (state_d)
            IDLE:    tx_d = 1'b1;
            START:   tx_d = 1'b0;
            DATA:    tx_d = b_d[0];
            PARITY:  tx_d = p_d;
            STOP:    tx_d = 1'b1;
            default: tx_d = 1'b1;
        endcase
    end

    assign tx   = tx_q;
    assign busy = (state_q != IDLE);

endmodule
